mem_stage_sram_ctrl: RTL and testbench

MEM_STAGE_SRAM_CTRL -- requirements
Module: mem_stage_sram_ctrl

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 19 +
 rtl/mem_stage_sram_ctrl_wbuf.sv | 39 +++
 rtl/mem_stage_sram_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: datapath width,
// FSM state encoding and halfword-select constants.
`ifndef MAX_LENGTH
`define MAX_LENGTH 32
`endif

package mem_stage_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/mem_stage_sram_ctrl_wbuf.sv
// One-entry posted-store buffer (valid, addr, data); only present when
// MEM_WRITE_BUFFER_EN is defined. Clear wins over load.
`ifdef MEM_WRITE_BUFFER_EN
module mem_write_buffer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule
`endif

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: splits each 32-bit load/store into two 16-bit SRAM
// accesses (low half first). Define MEM_WRITE_BUFFER_EN to post stores.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [`MAX_LENGTH-1:0] address,
  input  logic [`MAX_LENGTH-1:0] st_value,
  output logic [`MAX_LENGTH-1:0] mem_read_value,
  output logic                   ready,
  output logic                   sram_req,
  output logic                   sram_we,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_wdata,
  input  logic [15:0]            sram_rdata,
  input  logic                   sram_ack
);

  state_e                 state_q;
  logic [15:0]            lo_q;
  logic [`MAX_LENGTH-1:0] rd_value_q;
  logic                   req_q;
  logic                   we_q;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic [15:0]            wdata_q;

  logic                   mem_req;
  logic                   load_op;
  logic                   posted;
  logic                   draining;
  logic [SRAM_ADDR_W-2:0] base;
  logic [15:0]            hi_data;
  logic                   unused_addr;

  assign mem_req     = mem_r_en | mem_w_en;
  assign load_op     = mem_r_en & ~mem_w_en;
  assign unused_addr = ^{address[`MAX_LENGTH-1:SRAM_ADDR_W+1], address[1:0]};

`ifdef MEM_WRITE_BUFFER_EN
  logic                   wb_valid;
  logic                   wb_clear;
  logic [`MAX_LENGTH-1:0] wb_addr;
  logic [`MAX_LENGTH-1:0] wb_data;
  logic                   unused_wb;

  assign posted   = (state_q == IDLE) & mem_w_en & ~wb_valid;
  assign wb_clear = reset | ((state_q == HIGH) & sram_ack & wb_valid);

  mem_write_buffer #(
    .ADDR_W(`MAX_LENGTH),
    .DATA_W(`MAX_LENGTH)
  ) u_wbuf (
    .clk_i  (clk),
    .load_i (posted),
    .clear_i(wb_clear),
    .addr_i (address),
    .data_i (st_value),
    .valid_o(wb_valid),
    .addr_o (wb_addr),
    .data_o (wb_data)
  );

  // During a drain the live inputs already belong to the next instruction,
  // so the upper half must come from the buffer entry.
  assign draining  = wb_valid;
  assign base      = draining ? wb_addr[SRAM_ADDR_W:2] : address[SRAM_ADDR_W:2];
  assign hi_data   = draining ? wb_data[`MAX_LENGTH-1:16] : st_value[`MAX_LENGTH-1:16];
  assign unused_wb = ^{wb_addr[`MAX_LENGTH-1:SRAM_ADDR_W+1], wb_addr[1:0], wb_data[15:0]};
`else
  assign posted   = 1'b0;
  assign draining = 1'b0;
  assign base     = address[SRAM_ADDR_W:2];
  assign hi_data  = st_value[`MAX_LENGTH-1:16];
`endif

  always_comb begin
    ready = 1'b1;
    unique case (state_q)
      IDLE:      ready = ~mem_req | posted;
      LOW, HIGH: ready = draining & ~mem_req;
      DONE:      ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lo_q       <= '0;
      rd_value_q <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_req) begin
            state_q <= LOW;
            req_q   <= 1'b1;
            we_q    <= mem_w_en;
            addr_q  <= {address[SRAM_ADDR_W:2], HALF_LO};
            wdata_q <= st_value[15:0];
          end
        end
        LOW: begin
          if (sram_ack) begin
            state_q <= HIGH;
            lo_q    <= sram_rdata;
            addr_q  <= {base, HALF_HI};
            wdata_q <= hi_data;
          end
        end
        HIGH: begin
          if (sram_ack) begin
            req_q <= 1'b0;
            if (draining) begin
              state_q <= IDLE;
            end else begin
              state_q <= DONE;
              if (load_op) rd_value_q <= {sram_rdata, lo_q};
            end
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read_value = rd_value_q;
  assign sram_req       = req_q;
  assign sram_we        = we_q;
  assign sram_addr      = addr_q;
  assign sram_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl: behavioural SRAM with
// programmable ack delay and a word-level reference memory.
module tb_mem_stage_sram_ctrl;

`ifdef MEM_WRITE_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [17:0] addr;
    logic [15:0] wd;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset, mem_r_en, mem_w_en;
  logic [31:0] address, st_value, mem_read_value;
  logic        ready, sram_req, sram_we;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata = '0;
  logic        sram_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  // SRAM model state and word-level reference
  logic [15:0]  sram_mem  [0:262143];
  logic [31:0]  ref_words [0:131071];
  acc_t         log_q[$];
  int unsigned  ack_delay = 1;
  int unsigned  cyc = 0;
  int unsigned  unstable_cnt = 0;
  int unsigned  post_ack_cnt = 0;
  logic         post_ack_pend = 1'b0;
  logic [17:0]  last_ack_addr, cap_addr;
  logic         cap_we;
  logic [15:0]  cap_wd;
  logic [31:0]  last_rv = '0;

  mem_stage_sram_ctrl #(.SRAM_ADDR_W(18)) dut (
    .clk(clk), .reset(reset), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .st_value(st_value), .mem_read_value(mem_read_value),
    .ready(ready), .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    acc_t e;
    if (post_ack_pend && sram_req && sram_addr == last_ack_addr) post_ack_cnt++;
    post_ack_pend = 1'b0;
    sram_ack = 1'b0;
    if (sram_req) begin
      cyc++;
      if (cyc == 1) begin
        cap_addr = sram_addr; cap_we = sram_we; cap_wd = sram_wdata;
      end else if (sram_addr !== cap_addr || sram_we !== cap_we ||
                   (sram_we && sram_wdata !== cap_wd)) begin
        unstable_cnt++;
      end
      if (cyc >= ack_delay) begin
        sram_ack   = 1'b1;
        sram_rdata = sram_mem[sram_addr];
        if (sram_we) sram_mem[sram_addr] = sram_wdata;
        e.we = sram_we; e.addr = sram_addr; e.wd = sram_wdata;
        log_q.push_back(e);
        last_ack_addr = sram_addr;
        post_ack_pend = 1'b1;
        cyc = 0;
      end
    end else begin
      cyc = 0;
    end
  end

  function automatic logic [17:0] half_of(input logic [31:0] a);
    int unsigned w;
    w = (a >> 2) & 32'h1FFFF;
    return 18'(w * 2);
  endfunction

  // Drives one request at posedge+1 and counts cycles until ready is seen.
  task automatic run_op(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int unsigned dly,
                        output int unsigned lat, output logic [31:0] rv);
    ack_delay = dly;
    mem_r_en = r; mem_w_en = w; address = a; st_value = d;
    lat = 0; rv = 'x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (ready) begin
        rv = mem_read_value;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic settle();
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!sram_req) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; st_value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", sram_req); end
    checks++; if (sram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", sram_we); end
    checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr got %h want 0", sram_addr); end
    checks++; if (sram_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", sram_wdata); end
    checks++; if (mem_read_value !== 32'h0) begin errors++; $display("FAIL reset_rv got %h want 0", mem_read_value); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1 || sram_req !== 1'b0) begin
      errors++; $display("FAIL idle_noreq got ready=%b req=%b want ready=1 req=0", ready, sram_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_basic();
    int unsigned lat, b;
    logic [31:0] rv;
    sram_mem[4] = 16'h1234; sram_mem[5] = 16'hABCD; ref_words[2] = 32'hABCD1234;
    b = log_q.size();
    run_op(1'b1, 1'b0, 32'h0000_0008, '0, 1, lat, rv);
    last_rv = 32'hABCD1234;
    checks++; if (lat != 4) begin errors++; $display("FAIL load_latency got %0d want 4", lat); end
    checks++; if (rv !== 32'hABCD1234) begin errors++; $display("FAIL load_value got %h want abcd1234", rv); end
    checks++; if (log_q.size() != b + 2) begin
      errors++; $display("FAIL load_accesses got %0d want 2", log_q.size() - b);
    end else begin
      checks++; if (log_q[b].addr !== 18'd4 || log_q[b+1].addr !== 18'd5 || log_q[b].we || log_q[b+1].we) begin
        errors++; $display("FAIL load_addrs got %0d,%0d want 4,5 reads", log_q[b].addr, log_q[b+1].addr);
      end
    end
    settle();
  endtask

  task automatic test_store();
    int unsigned lat, b;
    logic [31:0] rv, prev;
    acc_t e0, e1;
    prev = last_rv;
    b = log_q.size();
    ref_words[4] = 32'hDEADBEEF;
    run_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1, lat, rv);
    checks++; if (lat != (BUF ? 1 : 4)) begin errors++; $display("FAIL store_latency got %0d want %0d", lat, BUF ? 1 : 4); end
    checks++; if (rv !== prev) begin errors++; $display("FAIL store_rv got %h want %h", rv, prev); end
`ifdef MEM_WRITE_BUFFER_EN
    run_op(1'b1, 1'b0, 32'h10, '0, 1, lat, rv);
    last_rv = 32'hDEADBEEF;
    checks++; if (lat != 6) begin errors++; $display("FAIL drain_load_latency got %0d want 6", lat); end
    checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL drain_load_value got %h want deadbeef", rv); end
`endif
    settle();
    e0 = '{we: 1'b1, addr: 18'd8, wd: 16'hBEEF};
    e1 = '{we: 1'b1, addr: 18'd9, wd: 16'hDEAD};
    checks++; if (log_q.size() < b + 2) begin
      errors++; $display("FAIL store_accesses got %0d want 2", log_q.size() - b);
    end else begin
      checks++; if (log_q[b] !== e0 || log_q[b+1] !== e1) begin
        errors++; $display("FAIL store_halves got %h,%h want %h,%h", log_q[b], log_q[b+1], e0, e1);
      end
    end
  endtask

  task automatic test_both();
    int unsigned lat, b;
    logic [31:0] rv, prev;
    acc_t e0, e1;
    prev = last_rv;
    b = log_q.size();
    ref_words[8] = 32'h5;
    run_op(1'b1, 1'b1, 32'h20, 32'h5, 1, lat, rv);
    settle();
    e0 = '{we: 1'b1, addr: 18'd16, wd: 16'h0005};
    e1 = '{we: 1'b1, addr: 18'd17, wd: 16'h0000};
    checks++; if (lat != (BUF ? 1 : 4)) begin errors++; $display("FAIL both_latency got %0d want %0d", lat, BUF ? 1 : 4); end
    checks++; if (mem_read_value !== prev) begin errors++; $display("FAIL both_rv got %h want %h", mem_read_value, prev); end
    checks++; if (log_q.size() != b + 2) begin
      errors++; $display("FAIL both_accesses got %0d want 2", log_q.size() - b);
    end else begin
      checks++; if (log_q[b] !== e0 || log_q[b+1] !== e1) begin
        errors++; $display("FAIL both_halves got %h,%h want %h,%h", log_q[b], log_q[b+1], e0, e1);
      end
    end
  endtask

  task automatic test_slow_ack();
    int unsigned lat, un0, pa0, idx;
    logic [31:0] rv, a, d;
    un0 = unstable_cnt; pa0 = post_ack_cnt;
    a = $urandom; idx = (a >> 2) & 32'h1FFFF;
    run_op(1'b1, 1'b0, a, '0, 5, lat, rv);
    last_rv = ref_words[idx];
    checks++; if (lat != 12) begin errors++; $display("FAIL slow_load_latency got %0d want 12", lat); end
    checks++; if (rv !== ref_words[idx]) begin errors++; $display("FAIL slow_load_value got %h want %h", rv, ref_words[idx]); end
    settle();
    a = $urandom; d = $urandom; idx = (a >> 2) & 32'h1FFFF;
    ref_words[idx] = d;
    run_op(1'b0, 1'b1, a, d, 5, lat, rv);
    settle();
    checks++; if (lat != (BUF ? 1 : 12)) begin errors++; $display("FAIL slow_store_latency got %0d want %0d", lat, BUF ? 1 : 12); end
    checks++; if (unstable_cnt != un0) begin errors++; $display("FAIL slow_stability got %0d changes want 0", unstable_cnt - un0); end
    checks++; if (post_ack_cnt != pa0) begin errors++; $display("FAIL req_after_ack got %0d want 0", post_ack_cnt - pa0); end
  endtask

  task automatic test_back_to_back();
    int unsigned lat, b, idx, dly, exp_lat, pa0, un0;
    logic r, w;
    logic [31:0] a, d, rv, exp_rv;
    logic [17:0] h;
    pa0 = post_ack_cnt; un0 = unstable_cnt;
    for (int n = 0; n < 40; n++) begin
      r = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      if (n < 4) begin r = 1'b1; w = 1'b0; end
      a = $urandom; d = $urandom; dly = $urandom_range(1, 4);
      idx = (a >> 2) & 32'h1FFFF;
      h = half_of(a);
      if (w) begin
        ref_words[idx] = d;
        exp_rv = last_rv;
        exp_lat = BUF ? 1 : 2 + 2 * dly;
      end else begin
        exp_rv = ref_words[idx];
        last_rv = exp_rv;
        exp_lat = 2 + 2 * dly;
      end
      b = log_q.size();
      run_op(r, w, a, d, dly, lat, rv);
      if (BUF) settle();
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL b2b_latency op%0d got %0d want %0d", n, lat, exp_lat); end
      checks++; if (rv !== exp_rv) begin errors++; $display("FAIL b2b_value op%0d got %h want %h", n, rv, exp_rv); end
      checks++; if (log_q.size() != b + 2) begin
        errors++; $display("FAIL b2b_accesses op%0d got %0d want 2", n, log_q.size() - b);
      end else begin
        checks++;
        if (log_q[b].we !== w || log_q[b+1].we !== w || log_q[b].addr !== h || log_q[b+1].addr !== h + 18'd1 ||
            (w && (log_q[b].wd !== d[15:0] || log_q[b+1].wd !== d[31:16]))) begin
          errors++; $display("FAIL b2b_halves op%0d got %h,%h want we=%b addr=%h data=%h", n, log_q[b], log_q[b+1], w, h, d);
        end
      end
    end
    settle();
    checks++; if (post_ack_cnt != pa0 || unstable_cnt != un0) begin
      errors++; $display("FAIL b2b_protocol got post_ack=%0d unstable=%0d want 0,0", post_ack_cnt - pa0, unstable_cnt - un0);
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    logic [31:0] a;
    int unsigned idx;
    a = $urandom; idx = (a >> 2) & 32'h1FFFF;
    ref_words[idx] = 32'hC0FFEE11;
    sram_mem[2*idx] = 16'hEE11; sram_mem[2*idx+1] = 16'hC0FF;
    ack_delay = 3;
    mem_r_en = 1'b1; mem_w_en = 1'b0; address = a;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sram_req && sram_addr[0]) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL reach_high got 0 want 1"); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_r_en = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", ready); end
    checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL midreset_req got %b want 0", sram_req); end
    checks++; if (mem_read_value !== 32'h0) begin errors++; $display("FAIL midreset_rv got %h want 0", mem_read_value); end
    last_rv = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] wv;
    for (int i = 0; i < 131072; i++) begin
      wv = $urandom;
      ref_words[i] = wv;
      sram_mem[2*i] = wv[15:0];
      sram_mem[2*i+1] = wv[31:16];
    end
    test_reset();
    test_load_basic();
    test_store();
    test_both();
    test_slow_ack();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
